// File: rtl/result_display.sv
// Result display stage: holds the remainder unit's result/flags and scans them
// onto a 4-digit common-anode 7-segment display, REFRESH_DIV cycles per digit.
module result_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] result,
    input  logic       zero,
    input  logic       divbyzero,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       loaded
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    // Segment codes, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          held_sign;
    logic [3:0]    held_mag;
    logic          held_zero;
    logic          held_dbz;

    logic [3:0]    ones;
    logic          tens;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Handshake: load is a strobe with no ready/backpressure; every rising
    // edge that sees load=1 captures result/zero/divbyzero, so a held load
    // recaptures each cycle and load=0 leaves the held values untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_sign <= 1'b0;
            held_mag  <= 4'd0;
            held_zero <= 1'b0;
            held_dbz  <= 1'b0;
            loaded    <= 1'b0;
        end else if (load) begin
            held_sign <= result[4];
            held_mag  <= result[3:0];
            held_zero <= zero;
            held_dbz  <= divbyzero;
            loaded    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Magnitude is only 0..15, so a single compare-and-subtract gives the digits.
    always_comb begin
        tens = (held_mag >= 4'd10);
        ones = tens ? (held_mag - 4'd10) : held_mag;
    end

    always_comb begin
        seg_next = SEG_BLANK;
        if (loaded) begin
            if (held_dbz) begin
                case (idx)
                    2'd3:    seg_next = SEG_E;
                    2'd2:    seg_next = SEG_R;
                    2'd1:    seg_next = SEG_R;
                    default: seg_next = SEG_BLANK;
                endcase
            end else if (held_zero) begin
                seg_next = (idx == 2'd0) ? SEG_ZERO : SEG_BLANK;
            end else begin
                case (idx)
                    2'd3:    seg_next = held_sign ? SEG_MINUS : SEG_BLANK;
                    2'd2:    seg_next = SEG_BLANK;
                    2'd1:    seg_next = tens ? SEG_ONE : SEG_BLANK;
                    default: seg_next = digit_seg(ones);
                endcase
            end
        end
    end

    always_comb begin
        an_next = ~(4'b0001 << idx);
    end

    // Outputs are registered from the pre-edge index and held data, so they
    // trail both by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 4'b1110;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display with REFRESH_DIV=4: table-driven digit checks plus
// hand-written reset, mid-dwell load and asynchronous reset sequences.
module tb_result_display;

    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SR = 7'b0101111;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic [4:0]      result;
        logic            zero;
        logic            dbz;
        logic [3:0][6:0] exp;   // exp[3] is digit 3 (leftmost)
    } vec_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic [4:0] result;
    logic       zero;
    logic       divbyzero;
    logic [6:0] seg;
    logic [3:0] an;
    logic       loaded;

    int tests;
    int fails;
    int edges;   // rising edges since rst was released

    vec_t vecs[12];

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .result    (result),
        .zero      (zero),
        .divbyzero (divbyzero),
        .seg       (seg),
        .an        (an),
        .loaded    (loaded)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        edges = 0;
    endtask

    task automatic capture(input logic [4:0] r, input logic z, input logic d);
        result = r;
        zero = z;
        divbyzero = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    function automatic logic [3:0] an_model(input int e);
        int i;
        i = ((e - 1) / DIV) % 4;
        return ~(4'b0001 << i);
    endfunction

    task automatic scan_check(input int v);
        logic [6:0] got[4];
        logic       ok;
        for (int d = 0; d < 4; d++) got[d] = 7'bxxxxxxx;
        for (int k = 0; k < 4 * DIV; k++) begin
            tick();
            ok = 1'b1;
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: ok = 1'b0;
            endcase
            if (!ok) check($sformatf("v%0d_an_onehot", v), {12'd0, an}, 16'h000e);
        end
        for (int d = 0; d < 4; d++)
            check($sformatf("v%0d_digit%0d", v, d), {9'd0, got[d]}, {9'd0, vecs[v].exp[d]});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        edges = 0;
        rst = 1'b0;
        load = 1'b0;
        result = 5'd0;
        zero = 1'b0;
        divbyzero = 1'b0;

        vecs[0]  = '{5'b00101, 1'b0, 1'b0, {SB, SB, SB, S5}};
        vecs[1]  = '{5'b11101, 1'b0, 1'b0, {SM, SB, S1, S3}};
        vecs[2]  = '{5'b10000, 1'b1, 1'b0, {SB, SB, SB, S0}};
        vecs[3]  = '{5'b10000, 1'b1, 1'b1, {SE, SR, SR, SB}};
        vecs[4]  = '{5'b01010, 1'b0, 1'b0, {SB, SB, S1, S0}};
        vecs[5]  = '{5'b01111, 1'b0, 1'b0, {SB, SB, S1, S5}};
        vecs[6]  = '{5'b10111, 1'b0, 1'b0, {SM, SB, SB, S7}};
        vecs[7]  = '{5'b00000, 1'b0, 1'b0, {SB, SB, SB, S0}};
        vecs[8]  = '{5'b11001, 1'b0, 1'b0, {SM, SB, SB, S9}};
        vecs[9]  = '{5'b00111, 1'b1, 1'b0, {SB, SB, SB, S0}};
        vecs[10] = '{5'b10110, 1'b0, 1'b0, {SM, SB, SB, S6}};
        vecs[11] = '{5'b01100, 1'b0, 1'b0, {SB, SB, S1, S2}};

        // Reset, then idle: blank, scanning, not loaded.
        do_reset();
        check("reset_seg", {9'd0, seg}, {9'd0, SB});
        check("reset_an", {12'd0, an}, 16'h000e);
        check("reset_loaded", {15'd0, loaded}, 16'd0);
        for (int e = 1; e <= 4 * 4 * DIV + 2; e++) begin
            tick();
            check($sformatf("idle_an_e%0d", e), {12'd0, an}, {12'd0, an_model(e)});
            check($sformatf("idle_seg_e%0d", e), {9'd0, seg}, {9'd0, SB});
            check($sformatf("idle_loaded_e%0d", e), {15'd0, loaded}, 16'd0);
        end

        // Table of captured values.
        for (int v = 0; v < 12; v++) begin
            capture(vecs[v].result, vecs[v].zero, vecs[v].dbz);
            check($sformatf("v%0d_loaded", v), {15'd0, loaded}, 16'd1);
            scan_check(v);
        end

        // Load mid-dwell: capture while an=1110 with the counter at 2.
        do_reset();
        capture(5'b00011, 1'b0, 1'b0);
        while (edges < 18) tick();
        check("mid_pre_an", {12'd0, an}, 16'h000e);
        check("mid_pre_seg", {9'd0, seg}, {9'd0, S3});
        capture(5'b00111, 1'b0, 1'b0);
        check("mid_cap_an", {12'd0, an}, 16'h000e);
        check("mid_cap_seg_old", {9'd0, seg}, {9'd0, S3});
        tick();
        check("mid_next_an", {12'd0, an}, 16'h000e);
        check("mid_next_seg_new", {9'd0, seg}, {9'd0, S7});
        tick();
        check("mid_after_an", {12'd0, an}, 16'h000d);
        check("mid_after_seg", {9'd0, seg}, {9'd0, SB});
        tick();
        check("mid_after2_an", {12'd0, an}, {12'd0, an_model(edges)});

        // Asynchronous reset mid-scan while an=1011, with load held during reset.
        while (an_model(edges) != 4'b1011) tick();
        check("arst_pre_an", {12'd0, an}, 16'h000b);
        #3;
        rst = 1'b1;
        #1;
        check("arst_seg", {9'd0, seg}, {9'd0, SB});
        check("arst_an", {12'd0, an}, 16'h000e);
        check("arst_loaded", {15'd0, loaded}, 16'd0);
        result = 5'b00101;
        load = 1'b1;
        @(posedge clk);
        #3;
        check("arst_load_ignored", {15'd0, loaded}, 16'd0);
        load = 1'b0;
        rst = 1'b0;
        edges = 0;
        tick();
        check("post_rst_an", {12'd0, an}, 16'h000e);
        check("post_rst_seg", {9'd0, seg}, {9'd0, SB});
        check("post_rst_loaded", {15'd0, loaded}, 16'd0);
        capture(5'b01001, 1'b0, 1'b0);
        check("post_rst_cap_loaded", {15'd0, loaded}, 16'd1);
        tick();
        check("post_rst_cap_seg", {9'd0, seg}, {9'd0, S9});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
